// File: rtl/operand_multiplier.sv
// Iterative 128x128 unsigned multiplier feeding the modular-reduction stage.
// Optional build macro: OPERAND_MUL_RADIX4_EN (radix-4, 64 iterations; default radix-2, 128).
module operand_multiplier (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [127:0] X,
  input  logic [127:0] Y,
  input  logic [127:0] N,
  output logic         busy,
  output logic         err,
  output logic [255:0] A,
  output logic [127:0] B,
  output logic         dividend_valid,
  output logic         divisor_valid
);

`ifdef OPERAND_MUL_RADIX4_EN
  localparam int unsigned K = 64;
`else
  localparam int unsigned K = 128;
`endif
  localparam int unsigned CW = $clog2(K);

  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

  state_t          state_q;
  logic [127:0]    mcand_q, mplier_q, mod_q, mplier_d;
  logic [255:0]    acc_q, acc_d, a_q;
  logic [127:0]    b_q;
  logic [CW-1:0]   cnt_q;
  logic            valid_q, err_q;
  logic            last_iter;

`ifdef OPERAND_MUL_RADIX4_EN
  logic [129:0] mcand3_q, addend, sum;

  // Upper half plus at most 3*mcand stays below 2^130, so 130 bits hold the sum.
  always_comb begin
    unique case (mplier_q[1:0])
      2'd0:    addend = '0;
      2'd1:    addend = {2'b00, mcand_q};
      2'd2:    addend = {1'b0, mcand_q, 1'b0};
      default: addend = mcand3_q;
    endcase
    sum      = {2'b00, acc_q[255:128]} + addend;
    acc_d    = {sum, acc_q[127:2]};
    mplier_d = {2'b00, mplier_q[127:2]};
  end
`else
  logic [128:0] sum;

  always_comb begin
    sum      = {1'b0, acc_q[255:128]} + (mplier_q[0] ? {1'b0, mcand_q} : 129'd0);
    acc_d    = {sum, acc_q[127:1]};
    mplier_d = {1'b0, mplier_q[127:1]};
  end
`endif

  assign last_iter = (cnt_q == CW'(K - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      mod_q    <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
`ifdef OPERAND_MUL_RADIX4_EN
      mcand3_q <= '0;
`endif
    end else begin
      err_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            if (N == '0) begin
              err_q <= 1'b1;
            end else begin
              mcand_q  <= X;
              mplier_q <= Y;
              mod_q    <= N;
              acc_q    <= '0;
              cnt_q    <= '0;
`ifdef OPERAND_MUL_RADIX4_EN
              mcand3_q <= {2'b00, X} + {1'b0, X, 1'b0};
`endif
              state_q  <= MUL;
            end
          end
        end
        MUL: begin
          acc_q    <= acc_d;
          mplier_q <= mplier_d;
          cnt_q    <= cnt_q + CW'(1);
          if (last_iter) begin
            a_q     <= acc_d;
            b_q     <= mod_q;
            valid_q <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          valid_q <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy           = (state_q != IDLE);
  assign err            = err_q;
  assign A              = a_q;
  assign B              = b_q;
  assign dividend_valid = valid_q;
  assign divisor_valid  = valid_q;

endmodule

// File: doc/operand_multiplier.md
# operand_multiplier

Iterative 128x128-bit unsigned multiplier that produces the 256-bit dividend and 128-bit divisor for the crypto datapath's modular-reduction stage. The block accepts two operands and a modulus, forms their full-width product over multiple cycles, then presents the product on `A` and the modulus on `B` with `dividend_valid` and `divisor_valid` asserted together for exactly one cycle. The downstream reducer samples both buses on that cycle.

## Interface
Parameters:
- none; all widths fixed: operands 128, product 256.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `start`  in  1  request; sampled only in IDLE.
- `X`  in  128  multiplicand, captured on the accepted `start`.
- `Y`  in  128  multiplier, captured on the accepted `start`.
- `N`  in  128  modulus, captured on the accepted `start`.
- `busy`  out  1  high whenever state != IDLE.
- `err`  out  1  one-cycle pulse when a request is rejected because N == 0.
- `A`  out  256  product X*Y; holds its value between results.
- `B`  out  128  captured modulus; holds its value between results.
- `dividend_valid`  out  1  one-cycle result strobe.
- `divisor_valid`  out  1  identical to `dividend_valid`, every cycle.

## Operation
- States: IDLE, MUL, DONE.
- IDLE, `start`=1, N != 0: latch X into `mcand`, Y into `mplier`, N into `mod_r`; clear the 256-bit accumulator and the iteration counter; go to MUL.
- IDLE, `start`=1, N == 0: pulse `err` for one cycle; stay in IDLE; latch nothing.
- MUL, one iteration per edge (radix-2):
  - If `mplier[0]`, add `mcand` into `acc[255:128]` with a 129-bit sum.
  - Shift the {carry, acc} concatenation right by 1.
  - Shift `mplier` right by 1.
  - Increment the counter.
- MUL exit: on the edge that completes the final iteration, load `A` <= final acc, load `B` <= `mod_r`, set both valids, go to DONE.
- DONE: on the next edge, clear both valids and go to IDLE.
- Arithmetic is unsigned. The product always fits in 256 bits, so no overflow is possible. Maximum product: (2^128-1)^2 = 2^256 - 2^129 + 1.
- `start` in MUL or DONE is ignored, with no queueing and no `err`.
- Operand zero (X or Y == 0) still runs the full iteration count, with A=0. There is no early exit.
- Input changes after acceptance have no effect.
- Reset (any time, including mid-MUL): state=IDLE, `busy`=0, `err`=0, both valids=0, A=0, B=0, accumulator and counter cleared. An in-flight result is discarded and never strobed.

## Timing
- Accept edge = E0. MUL occupies edges E1..E(K).
  - K = 128 iterations in radix-2.
  - K = 64 iterations when `RADIX4_EN` is defined.
- Valids and new A/B are visible after edge E(K) and drop at edge E(K+1).
- `busy` rises after E0 and falls after E(K+1).
- The earliest next accept is edge E(K+2). Throughput is one result per K+2 cycles.
- `err` is visible after the edge that sampled the bad request, and is cleared on the next edge.

## Configuration
- `OPERAND_MUL_RADIX4_EN` defined: 2 multiplier bits retired per iteration.
  - Add 0, `mcand`, 2*`mcand` or 3*`mcand` into the upper half, then shift by 2.
  - 3*`mcand` is precomputed at accept time as a 130-bit register.
  - K = 64.
- `OPERAND_MUL_RADIX4_EN` undefined: radix-2, K = 128, no 3x register.
- Results, handshake and `err` behaviour are identical in both builds; only latency differs.

## Test plan
- X=3, Y=5, N=7 -> A=15, B=7, both valids high exactly one cycle, K cycles after the accept edge; `busy` high for K+1 cycles.
- X=Y=2^128-1, N=2^128-1 -> A=0xFFFF...FFFE0000...0001 (2^256-2^129+1), B=2^128-1.
- Pulse `start` at cycles 5, 40 and K+1 after the first accept, with different operands -> only the first request completes, no `err`; the next accept succeeds only at E(K+2).
- `start` with N=0 -> `err` high one cycle, `busy` stays 0, valids stay 0, A/B keep their prior values.
- Assert `rst_n`=0 for one cycle midway through MUL -> all outputs 0 immediately (asynchronous), no valid strobe follows; a fresh request with X=6, Y=7 then gives A=42.
- Back-to-back requests with random 128-bit X, Y, N (N != 0), 1000 iterations -> A matches the reference product X*Y and B matches N for every strobe; valids are never asserted outside DONE.
